// File: rtl/ppu_pkg.sv
// ppu_pkg: shared types and dot constants for the PPU VRAM arbiter.
//   owner_t     - current VRAM bus owner (none, background, sprite, CPU)
//   cpu_state_t - CPU data-port access state machine
//   DOT_*       - dot counter boundaries of the rendering fetch schedule
package ppu_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_BG   = 2'd1,
      OWN_SP   = 2'd2,
      OWN_CPU  = 2'd3
   } owner_t;

   typedef enum logic [1:0] {
      CPU_IDLE  = 2'd0,
      CPU_PEND  = 2'd1,
      CPU_GRANT = 2'd2,
      CPU_DATA  = 2'd3
   } cpu_state_t;

   localparam logic [9:0] DOT_SP_START    = 10'd256;
   localparam logic [9:0] DOT_BG_PF_START = 10'd320;
   localparam logic [9:0] DOT_IDLE_START  = 10'd336;
   localparam logic [9:0] DOT_LAST        = 10'd340;

endpackage

// File: rtl/ppu_vram_cpu_port.sv
// ppu_vram_cpu_port: CPU ($2007) side of the VRAM arbiter.
// Latches a one-cycle request, waits for a free bus slot, owns the bus for
// a single GRANT cycle, then acknowledges in the following DATA cycle.
// Ports:
//   clk, reset        - PPU clock, synchronous active-high reset
//   i_slot_free       - bus may be handed to the CPU on the next cycle
//   i_cpu_req/we/addr/wdata - request pulse and its operands
//   i_vram_rdata      - bus read data (one-cycle latency)
//   o_cpu_grant       - CPU owns the bus this cycle
//   o_cpu_busy/ack/rdata/drop - CPU status outputs
//   o_we_q/o_addr_q/o_wdata_q - latched request operands for the bus mux
module ppu_vram_cpu_port
   import ppu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        i_slot_free,
   input  logic        i_cpu_req,
   input  logic        i_cpu_we,
   input  logic [13:0] i_cpu_addr,
   input  logic [7:0]  i_cpu_wdata,
   input  logic [7:0]  i_vram_rdata,
   output logic        o_cpu_grant,
   output logic        o_cpu_busy,
   output logic        o_cpu_ack,
   output logic [7:0]  o_cpu_rdata,
   output logic        o_cpu_drop,
   output logic        o_we_q,
   output logic [13:0] o_addr_q,
   output logic [7:0]  o_wdata_q
);

   cpu_state_t  r_state;
   cpu_state_t  w_next;
   logic        r_we;
   logic [13:0] r_addr;
   logic [7:0]  r_wdata;
   logic [7:0]  r_rdata;
   logic        r_drop;
   logic        w_capture;

   // State register
   always_ff @(posedge clk) begin
      if (reset) r_state <= CPU_IDLE;
      else       r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         CPU_IDLE:  if (i_cpu_req)   w_next = CPU_PEND;
         CPU_PEND:  if (i_slot_free) w_next = CPU_GRANT;
         CPU_GRANT: w_next = CPU_DATA;
         CPU_DATA:  w_next = CPU_IDLE;
         default:   w_next = CPU_IDLE;
      endcase
   end

   // Outputs; grant/ack are masked by reset so an abandoned access neither
   // drives the bus nor acknowledges in the reset cycle.
   always_comb begin
      o_cpu_busy  = (r_state != CPU_IDLE);
      o_cpu_grant = (r_state == CPU_GRANT) && !reset;
      o_cpu_ack   = (r_state == CPU_DATA)  && !reset;
   end

   // Read data is presented combinationally in the ack cycle so cpu_rdata
   // is valid together with cpu_ack, then held in r_rdata.
   assign w_capture   = o_cpu_ack && !r_we;
   assign o_cpu_rdata = w_capture ? i_vram_rdata : r_rdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_drop  <= 1'b0;
      end else begin
         if ((r_state == CPU_IDLE) && i_cpu_req) begin
            r_we    <= i_cpu_we;
            r_addr  <= i_cpu_addr;
            r_wdata <= i_cpu_wdata;
         end
         if (i_cpu_req && o_cpu_busy) r_drop <= 1'b1;
         if (w_capture) r_rdata <= i_vram_rdata;
      end
   end

   assign o_cpu_drop = r_drop;
   assign o_we_q     = r_we;
   assign o_addr_q   = r_addr;
   assign o_wdata_q  = r_wdata;

endmodule

// File: rtl/ppu_vram_arbiter.sv
// ppu_vram_arbiter: schedules the single PPU VRAM bus among the background
// fetcher, sprite fetcher and CPU data port, and routes read data back to
// the requester that owned the bus one cycle earlier.
// Configuration macro: PPU_ARB_CPU_STEAL_EN - when defined, the CPU may be
// granted during rendering in the idle dots 336..340; otherwise only while
// rendering is off.
// Ports:
//   clk, reset               - PPU clock, synchronous active-high reset
//   rendering, x_idx         - rendering enable and current dot (0..340)
//   bg_addr/sp_addr          - fetcher addresses
//   bg_data/sp_data          - routed read data to fetchers
//   cpu_req/we/addr/wdata    - CPU access request
//   cpu_busy/ack/rdata/drop  - CPU status
//   vram_addr/we/wdata/rdata - VRAM bus
module ppu_vram_arbiter
   import ppu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        rendering,
   input  logic [9:0]  x_idx,
   input  logic [15:0] bg_addr,
   input  logic [15:0] sp_addr,
   output logic [7:0]  bg_data,
   output logic [7:0]  sp_data,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [13:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic        cpu_busy,
   output logic        cpu_ack,
   output logic [7:0]  cpu_rdata,
   output logic        cpu_drop,
   output logic [15:0] vram_addr,
   output logic        vram_we,
   output logic [7:0]  vram_wdata,
   input  logic [7:0]  vram_rdata
);

   owner_t      w_owner;
   owner_t      r_owner_q;
   logic        w_slot_free;
   logic        w_cpu_grant;
   logic        w_we_q;
   logic [13:0] w_addr_q;
   logic [7:0]  w_wdata_q;

`ifdef PPU_ARB_CPU_STEAL_EN
   // The grant decision is made one dot ahead so that the GRANT cycle itself
   // falls on an idle dot (336..340) and never lands on BG dot 0 after wrap.
   assign w_slot_free = !rendering ||
                        ((x_idx >= DOT_IDLE_START - 10'd1) && (x_idx <= DOT_LAST - 10'd1));
`else
   assign w_slot_free = !rendering;
`endif

   ppu_vram_cpu_port u_cpu_port (
      .clk          (clk),
      .reset        (reset),
      .i_slot_free  (w_slot_free),
      .i_cpu_req    (cpu_req),
      .i_cpu_we     (cpu_we),
      .i_cpu_addr   (cpu_addr),
      .i_cpu_wdata  (cpu_wdata),
      .i_vram_rdata (vram_rdata),
      .o_cpu_grant  (w_cpu_grant),
      .o_cpu_busy   (cpu_busy),
      .o_cpu_ack    (cpu_ack),
      .o_cpu_rdata  (cpu_rdata),
      .o_cpu_drop   (cpu_drop),
      .o_we_q       (w_we_q),
      .o_addr_q     (w_addr_q),
      .o_wdata_q    (w_wdata_q)
   );

   // Owner decode from the dot schedule; CPU GRANT overrides the schedule.
   always_comb begin
      w_owner = OWN_NONE;
      if (reset)            w_owner = OWN_NONE;
      else if (w_cpu_grant) w_owner = OWN_CPU;
      else if (rendering) begin
         if (x_idx < DOT_SP_START)                                   w_owner = OWN_BG;
         else if (x_idx < DOT_BG_PF_START)                           w_owner = OWN_SP;
         else if (x_idx < DOT_IDLE_START)                            w_owner = OWN_BG;
         else                                                        w_owner = OWN_NONE;
      end
   end

   // Bus mux; write strobe and write data only ever come from the CPU.
   always_comb begin
      vram_addr  = 16'h0000;
      vram_we    = 1'b0;
      vram_wdata = 8'h00;
      case (w_owner)
         OWN_BG:  vram_addr = bg_addr;
         OWN_SP:  vram_addr = sp_addr;
         OWN_CPU: begin
            vram_addr  = {2'b00, w_addr_q};
            vram_we    = w_we_q;
            vram_wdata = w_wdata_q;
         end
         default: vram_addr = 16'h0000;
      endcase
   end

   // Read data returns one cycle after the address, so route by last owner.
   always_ff @(posedge clk) begin
      if (reset) r_owner_q <= OWN_NONE;
      else       r_owner_q <= w_owner;
   end

   assign bg_data = (r_owner_q == OWN_BG) ? vram_rdata : 8'h00;
   assign sp_data = (r_owner_q == OWN_SP) ? vram_rdata : 8'h00;

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
module tb_ppu_vram_arbiter;

   logic        clk;
   logic        reset;
   logic        rendering;
   logic [9:0]  x_idx;
   logic [15:0] bg_addr;
   logic [15:0] sp_addr;
   logic [7:0]  bg_data;
   logic [7:0]  sp_data;
   logic        cpu_req;
   logic        cpu_we;
   logic [13:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_busy;
   logic        cpu_ack;
   logic [7:0]  cpu_rdata;
   logic        cpu_drop;
   logic [15:0] vram_addr;
   logic        vram_we;
   logic [7:0]  vram_wdata;
   logic [7:0]  vram_rdata;

   int checks;
   int errors;

   ppu_vram_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .rendering  (rendering),
      .x_idx      (x_idx),
      .bg_addr    (bg_addr),
      .sp_addr    (sp_addr),
      .bg_data    (bg_data),
      .sp_data    (sp_data),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_busy   (cpu_busy),
      .cpu_ack    (cpu_ack),
      .cpu_rdata  (cpu_rdata),
      .cpu_drop   (cpu_drop),
      .vram_addr  (vram_addr),
      .vram_we    (vram_we),
      .vram_wdata (vram_wdata),
      .vram_rdata (vram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; rendering = 1'b0; x_idx = 10'd0; bg_addr = 16'h1111; sp_addr = 16'h2222;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; vram_rdata = 8'hAA;
      tick(); tick(); #1;
      checks++; if (cpu_busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got %0h exp 0", cpu_busy); end
      checks++; if (cpu_ack !== 1'b0)       begin errors++; $display("FAIL rst_ack got %0h exp 0", cpu_ack); end
      checks++; if (cpu_rdata !== 8'h00)    begin errors++; $display("FAIL rst_rdata got %0h exp 0", cpu_rdata); end
      checks++; if (cpu_drop !== 1'b0)      begin errors++; $display("FAIL rst_drop got %0h exp 0", cpu_drop); end
      checks++; if (bg_data !== 8'h00)      begin errors++; $display("FAIL rst_bg_data got %0h exp 0", bg_data); end
      checks++; if (sp_data !== 8'h00)      begin errors++; $display("FAIL rst_sp_data got %0h exp 0", sp_data); end
      checks++; if (vram_addr !== 16'h0000) begin errors++; $display("FAIL rst_vaddr got %0h exp 0", vram_addr); end
      checks++; if (vram_we !== 1'b0)       begin errors++; $display("FAIL rst_vwe got %0h exp 0", vram_we); end
      checks++; if (vram_wdata !== 8'h00)   begin errors++; $display("FAIL rst_vwdata got %0h exp 0", vram_wdata); end
      tick(); reset = 1'b0; #1;
      checks++; if (cpu_busy !== 1'b0)      begin errors++; $display("FAIL post_rst_busy got %0h exp 0", cpu_busy); end
   endtask

   task automatic test_cpu_write();
      rendering = 1'b0; x_idx = 10'd123;
      tick(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h2005; cpu_wdata = 8'h5A; #1;
      checks++; if (vram_we !== 1'b0)       begin errors++; $display("FAIL wr_t0_we got %0h exp 0", vram_we); end
      tick(); cpu_req = 1'b0; cpu_addr = 14'h0777; cpu_wdata = 8'hEE; #1;
      checks++; if (cpu_busy !== 1'b1)      begin errors++; $display("FAIL wr_t1_busy got %0h exp 1", cpu_busy); end
      checks++; if (vram_we !== 1'b0)       begin errors++; $display("FAIL wr_t1_we got %0h exp 0", vram_we); end
      tick(); #1;
      checks++; if (vram_we !== 1'b1)       begin errors++; $display("FAIL wr_t2_we got %0h exp 1", vram_we); end
      checks++; if (vram_addr !== 16'h2005) begin errors++; $display("FAIL wr_t2_addr got %0h exp 2005", vram_addr); end
      checks++; if (vram_wdata !== 8'h5A)   begin errors++; $display("FAIL wr_t2_wdata got %0h exp 5a", vram_wdata); end
      checks++; if (cpu_ack !== 1'b0)       begin errors++; $display("FAIL wr_t2_ack got %0h exp 0", cpu_ack); end
      tick(); #1;
      checks++; if (vram_we !== 1'b0)       begin errors++; $display("FAIL wr_t3_we got %0h exp 0", vram_we); end
      checks++; if (cpu_ack !== 1'b1)       begin errors++; $display("FAIL wr_t3_ack got %0h exp 1", cpu_ack); end
      tick(); #1;
      checks++; if (cpu_ack !== 1'b0)       begin errors++; $display("FAIL wr_t4_ack got %0h exp 0", cpu_ack); end
      checks++; if (cpu_busy !== 1'b0)      begin errors++; $display("FAIL wr_t4_busy got %0h exp 0", cpu_busy); end
      checks++; if (cpu_drop !== 1'b0)      begin errors++; $display("FAIL wr_drop got %0h exp 0", cpu_drop); end
   endtask

   task automatic test_route();
      tick(); rendering = 1'b1; x_idx = 10'd300; bg_addr = 16'h2001; sp_addr = 16'h1230; vram_rdata = 8'h00; #1;
      checks++; if (vram_addr !== 16'h1230) begin errors++; $display("FAIL sp_addr got %0h exp 1230", vram_addr); end
      tick(); vram_rdata = 8'h77; #1;
      checks++; if (sp_data !== 8'h77)      begin errors++; $display("FAIL sp_data got %0h exp 77", sp_data); end
      checks++; if (bg_data !== 8'h00)      begin errors++; $display("FAIL sp_bg_data got %0h exp 0", bg_data); end
      tick(); x_idx = 10'd10; vram_rdata = 8'h00; #1;
      checks++; if (vram_addr !== 16'h2001) begin errors++; $display("FAIL bg_addr got %0h exp 2001", vram_addr); end
      tick(); vram_rdata = 8'h33; #1;
      checks++; if (bg_data !== 8'h33)      begin errors++; $display("FAIL bg_data got %0h exp 33", bg_data); end
      checks++; if (sp_data !== 8'h00)      begin errors++; $display("FAIL bg_sp_data got %0h exp 0", sp_data); end
   endtask

   task automatic test_cpu_read_pending();
      int grant_dot;
      int ack_dot;
      logic [7:0] ack_rdata;
      grant_dot = -1; ack_dot = -1; ack_rdata = 8'h00;
      tick(); rendering = 1'b1; x_idx = 10'd100; bg_addr = 16'h0123; sp_addr = 16'h0456;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h3F00; cpu_wdata = 8'h00; vram_rdata = 8'hC3; #1;
      for (int d = 101; d <= 340; d++) begin
         tick(); cpu_req = 1'b0; x_idx = 10'(d); #1;
         if (vram_addr === 16'h3F00 && grant_dot < 0) grant_dot = d;
         if (cpu_ack === 1'b1 && ack_dot < 0) begin ack_dot = d; ack_rdata = cpu_rdata; end
      end
`ifdef PPU_ARB_CPU_STEAL_EN
      checks++; if (grant_dot != 336)       begin errors++; $display("FAIL steal_grant_dot got %0d exp 336", grant_dot); end
      checks++; if (ack_dot != 337)         begin errors++; $display("FAIL steal_ack_dot got %0d exp 337", ack_dot); end
      checks++; if (ack_rdata !== 8'hC3)    begin errors++; $display("FAIL steal_ack_rdata got %0h exp c3", ack_rdata); end
      tick(); x_idx = 10'd0; #1;
      checks++; if (cpu_busy !== 1'b0)      begin errors++; $display("FAIL steal_busy got %0h exp 0", cpu_busy); end
      checks++; if (vram_addr !== 16'h0123) begin errors++; $display("FAIL steal_dot0_addr got %0h exp 0123", vram_addr); end
      checks++; if (cpu_rdata !== 8'hC3)    begin errors++; $display("FAIL steal_rdata_hold got %0h exp c3", cpu_rdata); end
`else
      checks++; if (grant_dot != -1)        begin errors++; $display("FAIL nosteal_grant_dot got %0d exp -1", grant_dot); end
      checks++; if (ack_dot != -1)          begin errors++; $display("FAIL nosteal_ack_dot got %0d exp -1", ack_dot); end
      checks++; if (cpu_busy !== 1'b1)      begin errors++; $display("FAIL nosteal_busy got %0h exp 1", cpu_busy); end
      tick(); rendering = 1'b0; x_idx = 10'd0; #1;
      checks++; if (cpu_ack !== 1'b0)       begin errors++; $display("FAIL nosteal_r0_ack got %0h exp 0", cpu_ack); end
      tick(); #1;
      checks++; if (vram_addr !== 16'h3F00) begin errors++; $display("FAIL nosteal_grant_addr got %0h exp 3f00", vram_addr); end
      checks++; if (vram_we !== 1'b0)       begin errors++; $display("FAIL nosteal_grant_we got %0h exp 0", vram_we); end
      tick(); #1;
      checks++; if (cpu_ack !== 1'b1)       begin errors++; $display("FAIL nosteal_ack got %0h exp 1", cpu_ack); end
      checks++; if (cpu_rdata !== 8'hC3)    begin errors++; $display("FAIL nosteal_ack_rdata got %0h exp c3", cpu_rdata); end
      tick(); vram_rdata = 8'h00; #1;
      checks++; if (cpu_busy !== 1'b0)      begin errors++; $display("FAIL nosteal_busy_end got %0h exp 0", cpu_busy); end
      checks++; if (cpu_rdata !== 8'hC3)    begin errors++; $display("FAIL nosteal_rdata_hold got %0h exp c3", cpu_rdata); end
`endif
   endtask

   task automatic test_sweep();
      logic [15:0] exp_addr;
      rendering = 1'b1;
      for (int d = 0; d <= 340; d++) begin
         tick(); x_idx = 10'(d); bg_addr = 16'(16'h1000 + d); sp_addr = 16'(16'h8000 + d); #1;
         if (d < 256)      exp_addr = 16'(16'h1000 + d);
         else if (d < 320) exp_addr = 16'(16'h8000 + d);
         else if (d < 336) exp_addr = 16'(16'h1000 + d);
         else              exp_addr = 16'h0000;
         checks++; if (vram_addr !== exp_addr) begin errors++; $display("FAIL sweep_addr dot %0d got %0h exp %0h", d, vram_addr, exp_addr); end
         checks++; if (vram_we !== 1'b0) begin errors++; $display("FAIL sweep_we dot %0d got %0h exp 0", d, vram_we); end
      end
   endtask

   task automatic test_back_to_back();
      tick(); rendering = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0100; cpu_wdata = 8'h11; #1;
      tick(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0200; cpu_wdata = 8'h22; #1;
      tick(); cpu_req = 1'b0; #1;
      checks++; if (vram_addr !== 16'h0100) begin errors++; $display("FAIL b2b_addr got %0h exp 0100", vram_addr); end
      checks++; if (vram_wdata !== 8'h11)   begin errors++; $display("FAIL b2b_wdata got %0h exp 11", vram_wdata); end
      checks++; if (vram_we !== 1'b1)       begin errors++; $display("FAIL b2b_we got %0h exp 1", vram_we); end
      checks++; if (cpu_drop !== 1'b1)      begin errors++; $display("FAIL b2b_drop got %0h exp 1", cpu_drop); end
      tick(); #1;
      checks++; if (cpu_ack !== 1'b1)       begin errors++; $display("FAIL b2b_ack got %0h exp 1", cpu_ack); end
      tick(); #1;
      tick(); #1;
      checks++; if (cpu_busy !== 1'b0)      begin errors++; $display("FAIL b2b_second_ignored got %0h exp 0", cpu_busy); end
      checks++; if (cpu_drop !== 1'b1)      begin errors++; $display("FAIL b2b_drop_sticky got %0h exp 1", cpu_drop); end
   endtask

   task automatic test_reset_in_grant();
      tick(); rendering = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h1234; cpu_wdata = 8'h99; #1;
      tick(); cpu_req = 1'b0; #1;
      tick(); reset = 1'b1; #1;
      checks++; if (vram_we !== 1'b0)       begin errors++; $display("FAIL rg_we got %0h exp 0", vram_we); end
      checks++; if (vram_addr !== 16'h0000) begin errors++; $display("FAIL rg_addr got %0h exp 0", vram_addr); end
      checks++; if (cpu_ack !== 1'b0)       begin errors++; $display("FAIL rg_ack got %0h exp 0", cpu_ack); end
      tick(); reset = 1'b0; #1;
      checks++; if (cpu_busy !== 1'b0)      begin errors++; $display("FAIL rg_busy got %0h exp 0", cpu_busy); end
      checks++; if (cpu_ack !== 1'b0)       begin errors++; $display("FAIL rg_ack_next got %0h exp 0", cpu_ack); end
      checks++; if (cpu_drop !== 1'b0)      begin errors++; $display("FAIL rg_drop got %0h exp 0", cpu_drop); end
      checks++; if (cpu_rdata !== 8'h00)    begin errors++; $display("FAIL rg_rdata got %0h exp 0", cpu_rdata); end
      checks++; if (vram_we !== 1'b0)       begin errors++; $display("FAIL rg_we_next got %0h exp 0", vram_we); end
      checks++; if (bg_data !== 8'h00)      begin errors++; $display("FAIL rg_bg_data got %0h exp 0", bg_data); end
      tick(); #1;
      checks++; if (cpu_ack !== 1'b0)       begin errors++; $display("FAIL rg_ack_late got %0h exp 0", cpu_ack); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_cpu_write();
      test_route();
      test_cpu_read_pending();
      test_sweep();
      test_back_to_back();
      test_reset_in_grant();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
